// File: rtl/wb_timer.sv
// Wishbone classic slave timer: 32-bit prescaled up-counter with compare match,
// optional auto-reload and a level interrupt gated by IRQ_EN.
module wb_timer #(
    parameter int unsigned PRESCALE_W = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0100
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ack_out,
    input  logic [31:0] addr_in,
    input  logic        cyc_in,
    input  logic        strobe_in,
    input  logic        we_in,
    output logic        irq
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = 3;

    localparam logic [IDX_W-1:0] IDX_CTRL     = 3'd0;
    localparam logic [IDX_W-1:0] IDX_PRESCALE = 3'd1;
    localparam logic [IDX_W-1:0] IDX_COMPARE  = 3'd2;
    localparam logic [IDX_W-1:0] IDX_COUNT    = 3'd3;
    localparam logic [IDX_W-1:0] IDX_STATUS   = 3'd4;

    logic                  ctrl_en;
    logic                  ctrl_autoreload;
    logic                  ctrl_irq_en;
    logic [PRESCALE_W-1:0] prescale;
    logic [PRESCALE_W-1:0] psc_cnt;
    logic [DATA_W-1:0]     compare;
    logic [DATA_W-1:0]     count;
    logic                  match;

    logic                  req_c;
    logic                  hit_c;
    logic [IDX_W-1:0]      idx_c;
    logic                  wr_c;
    logic                  ctrl_wr_c;
    logic                  prescale_wr_c;
    logic                  compare_wr_c;
    logic                  count_wr_c;
    logic                  status_wr_c;
    logic                  tick_c;
    logic                  match_now_c;
    logic [DATA_W-1:0]     rdata_c;
    logic                  unused_addr_c;

    // Bus decode; byte lanes are not supported so the low address bits are dropped.
    assign req_c         = cyc_in & strobe_in & ~ack_out;
    assign hit_c         = (addr_in[31:5] == BASE_ADDR[31:5]);
    assign idx_c         = addr_in[4:2];
    assign wr_c          = req_c & we_in & hit_c;
    assign ctrl_wr_c     = wr_c & (idx_c == IDX_CTRL);
    assign prescale_wr_c = wr_c & (idx_c == IDX_PRESCALE);
    assign compare_wr_c  = wr_c & (idx_c == IDX_COMPARE);
    assign count_wr_c    = wr_c & (idx_c == IDX_COUNT);
    assign status_wr_c   = wr_c & (idx_c == IDX_STATUS);
    assign unused_addr_c = &{1'b0, addr_in[1:0]};

    // A tick fires on the edge where the prescaler counter reaches PRESCALE.
    assign tick_c      = ctrl_en & (psc_cnt == prescale);
    assign match_now_c = tick_c & (count == compare) & ~count_wr_c;

    // Read mux; misses and unmapped slots return zero.
    always_comb begin
        rdata_c = '0;
        if (hit_c) begin
            case (idx_c)
                IDX_CTRL:     rdata_c = DATA_W'({ctrl_irq_en, ctrl_autoreload, ctrl_en});
                IDX_PRESCALE: rdata_c = DATA_W'(prescale);
                IDX_COMPARE:  rdata_c = compare;
                IDX_COUNT:    rdata_c = count;
                IDX_STATUS:   rdata_c = DATA_W'(match);
                default:      rdata_c = '0;
            endcase
        end
    end

    // Bus response: one-cycle ack, read data only alongside the ack.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ack_out  <= 1'b0;
            data_out <= '0;
        end else begin
            ack_out  <= req_c;
            data_out <= (req_c & ~we_in) ? rdata_c : '0;
        end
    end

    // Configuration registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_en         <= 1'b0;
            ctrl_autoreload <= 1'b0;
            ctrl_irq_en     <= 1'b0;
            prescale        <= '0;
            compare         <= '0;
        end else begin
            if (ctrl_wr_c) begin
                ctrl_en         <= data_in[0];
                ctrl_autoreload <= data_in[1];
                ctrl_irq_en     <= data_in[2];
            end
            if (prescale_wr_c) begin
                prescale <= data_in[PRESCALE_W-1:0];
            end
            if (compare_wr_c) begin
                compare <= data_in;
            end
        end
    end

    // Prescaler restarts on COUNT/PRESCALE writes and when counting is disabled.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            psc_cnt <= '0;
        end else if (count_wr_c || prescale_wr_c || (ctrl_wr_c && !data_in[0])) begin
            psc_cnt <= '0;
        end else if (ctrl_en) begin
            psc_cnt <= tick_c ? '0 : psc_cnt + PRESCALE_W'(1);
        end
    end

    // Counter, match flag and interrupt; a match set beats a same-edge clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            match <= 1'b0;
            irq   <= 1'b0;
        end else begin
            if (count_wr_c) begin
                count <= data_in;
            end else if (tick_c) begin
                if (match_now_c && ctrl_autoreload) begin
                    count <= '0;
                end else begin
                    count <= count + DATA_W'(1);
                end
            end

            if (match_now_c) begin
                match <= 1'b1;
            end else if (status_wr_c && data_in[0]) begin
                match <= 1'b0;
            end

            irq <= match & ctrl_irq_en;
        end
    end

endmodule

// File: tb/tb_wb_timer.sv
// Directed scoreboard bench for wb_timer: expected read data is queued at issue
// and checked by a monitor whenever the DUT acknowledges.
module tb_wb_timer;

    localparam logic [31:0] A_CTRL     = 32'h0000_0100;
    localparam logic [31:0] A_PRESCALE = 32'h0000_0104;
    localparam logic [31:0] A_COMPARE  = 32'h0000_0108;
    localparam logic [31:0] A_COUNT    = 32'h0000_010C;
    localparam logic [31:0] A_STATUS   = 32'h0000_0110;
    localparam logic [31:0] A_UNMAP    = 32'h0000_0114;
    localparam logic [31:0] A_MISS     = 32'h0000_0120;

    logic        clock;
    logic        reset_n;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        ack_out;
    logic [31:0] addr_in;
    logic        cyc_in;
    logic        strobe_in;
    logic        we_in;
    logic        irq;

    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;
    int          n_checks;
    int          n_fail;

    wb_timer #(
        .PRESCALE_W(16),
        .BASE_ADDR (32'h0000_0100)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .data_in  (data_in),
        .data_out (data_out),
        .ack_out  (ack_out),
        .addr_in  (addr_in),
        .cyc_in   (cyc_in),
        .strobe_in(strobe_in),
        .we_in    (we_in),
        .irq      (irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every ack consumes one queued expectation.
    always @(negedge clock) begin
        if (ack_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ack: got ack with data %h, expected no ack (t=%0t)", data_out, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                check("bus_data", data_out, mon_exp);
            end
        end
    end

    task automatic bus_idle();
        cyc_in    = 1'b0;
        strobe_in = 1'b0;
        we_in     = 1'b0;
    endtask

    // Single transfer: request sampled at the next rising edge, released after it.
    task automatic wb_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clock);
        cyc_in    = 1'b1;
        strobe_in = 1'b1;
        we_in     = 1'b1;
        addr_in   = addr;
        data_in   = data;
        exp_q.push_back(32'h0);
        @(posedge clock);
        @(negedge clock);
        bus_idle();
    endtask

    task automatic wb_read(input logic [31:0] addr, input logic [31:0] exp);
        @(negedge clock);
        cyc_in    = 1'b1;
        strobe_in = 1'b1;
        we_in     = 1'b0;
        addr_in   = addr;
        data_in   = 32'h0;
        exp_q.push_back(exp);
        @(posedge clock);
        @(negedge clock);
        bus_idle();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        addr_in  = 32'h0;
        data_in  = 32'h0;
        bus_idle();
        repeat (3) @(negedge clock);
        check("reset_ack", 32'(ack_out), 32'h0);
        check("reset_data", data_out, 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        reset_n = 1'b1;

        // Whole window reads zero after reset.
        for (int i = 0; i < 8; i++) begin
            wb_read(A_CTRL + 32'(i * 4), 32'h0);
        end
        check("irq_idle", 32'(irq), 32'h0);

        // Basic access, decode misses and unmapped slots.
        wb_write(A_COUNT, 32'h5);
        wb_read(A_COUNT, 32'h5);
        wb_write(A_MISS, 32'hDEAD);
        wb_read(A_MISS, 32'h0);
        wb_read(A_COUNT, 32'h5);
        wb_read(A_CTRL, 32'h0);
        wb_write(A_UNMAP, 32'hBEEF);
        wb_read(A_UNMAP, 32'h0);
        wb_write(A_CTRL, 32'hFFFF_FFF8);
        wb_read(A_CTRL, 32'h0);

        // Auto-reload: ticks every 4 clocks, count runs 0,1,2,0,... and irq follows the match.
        wb_write(A_PRESCALE, 32'h3);
        wb_write(A_COMPARE, 32'h2);
        wb_write(A_COUNT, 32'h0);
        wb_write(A_CTRL, 32'h7);
        for (int k = 1; k <= 14; k++) begin
            wb_read(A_COUNT, 32'(((k - 1) / 2) % 3));
            check("irq_autoreload", 32'(irq), (k >= 7) ? 32'h1 : 32'h0);
        end
        wb_write(A_CTRL, 32'h0);
        wb_read(A_STATUS, 32'h1);
        wb_write(A_STATUS, 32'h0);
        wb_read(A_STATUS, 32'h1);
        wb_write(A_STATUS, 32'h1);
        wb_read(A_STATUS, 32'h0);
        check("irq_cleared", 32'(irq), 32'h0);

        // Free-running wrap through zero with no flag.
        wb_write(A_PRESCALE, 32'h0);
        wb_write(A_COMPARE, 32'h10);
        wb_write(A_COUNT, 32'hFFFF_FFFE);
        wb_write(A_CTRL, 32'h1);
        wb_read(A_COUNT, 32'hFFFF_FFFF);
        wb_read(A_COUNT, 32'h1);
        wb_read(A_STATUS, 32'h0);
        wb_write(A_CTRL, 32'h0);

        // STATUS clear on the same edge as a match tick: the set wins.
        wb_write(A_COMPARE, 32'h1);
        wb_write(A_COUNT, 32'h0);
        wb_write(A_CTRL, 32'h1);
        wb_write(A_STATUS, 32'h1);
        wb_read(A_STATUS, 32'h1);
        wb_write(A_CTRL, 32'h0);
        wb_write(A_STATUS, 32'h1);
        wb_read(A_STATUS, 32'h0);

        // PRESCALE rewrite mid-count restarts the prescaler with the new period.
        wb_write(A_COUNT, 32'h0);
        wb_write(A_COMPARE, 32'hFFFF);
        wb_write(A_PRESCALE, 32'h7);
        wb_write(A_CTRL, 32'h1);
        wb_write(A_PRESCALE, 32'h1);
        wb_read(A_COUNT, 32'h0);
        wb_read(A_COUNT, 32'h1);
        wb_read(A_COUNT, 32'h2);
        wb_write(A_CTRL, 32'h0);

        // Strobe held for six cycles: ack alternates 1,0,1,0,1,0.
        wb_write(A_COUNT, 32'h1234);
        @(negedge clock);
        cyc_in    = 1'b1;
        strobe_in = 1'b1;
        we_in     = 1'b0;
        addr_in   = A_COUNT;
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h1234);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check("held_strobe_ack", 32'(ack_out), (i % 2 == 0) ? 32'h1 : 32'h0);
        end
        bus_idle();

        // Reset asserted while a write is being acknowledged.
        @(negedge clock);
        cyc_in    = 1'b1;
        strobe_in = 1'b1;
        we_in     = 1'b1;
        addr_in   = A_COMPARE;
        data_in   = 32'hABCD;
        @(posedge clock);
        #1;
        check("ack_before_reset", 32'(ack_out), 32'h1);
        reset_n = 1'b0;
        #1;
        check("ack_on_reset", 32'(ack_out), 32'h0);
        check("data_on_reset", data_out, 32'h0);
        @(negedge clock);
        bus_idle();
        @(negedge clock);
        reset_n = 1'b1;
        wb_read(A_COMPARE, 32'h0);
        wb_read(A_COUNT, 32'h0);
        wb_read(A_CTRL, 32'h0);
        check("irq_after_reset", 32'(irq), 32'h0);

        repeat (4) @(negedge clock);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_timer.md
Name: wb_timer

Overview:
- Wishbone classic slave peripheral: 32-bit prescaled up-counter with compare match, auto-reload and interrupt flag.
- Sits on the same bus as the register block, directly downstream of uart_wb_master.
- Its data/ack ports feed the master's data_in/ack_in through the top-level mux.
- Gives host software a timebase and periodic event over the serial-to-Wishbone link.

Parameters:
- PRESCALE_W, 16, width of the prescaler register and prescaler counter.
- BASE_ADDR, 32'h0000_0100, byte address of register 0; block decodes BASE_ADDR to BASE_ADDR+0x1F.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- data_in  in  32  write data from master
- data_out  out  32  read data to master
- ack_out  out  1  Wishbone acknowledge
- addr_in  in  32  byte address from master
- cyc_in  in  1  bus cycle valid
- strobe_in  in  1  transfer strobe
- we_in  in  1  1 = write, 0 = read
- irq  out  1  interrupt, level

Behaviour:
- Reset: one clock, reset asynchronous and active-low (reset_n low forces state immediately; release is synchronous to clock). All registers, prescaler counter, ack_out, data_out and irq are 0.
- Handshake:
  - Request = cyc_in & strobe_in & !ack_out, sampled at rising edge N.
  - At that edge, ack_out goes 1 for exactly one cycle. Read data is placed on data_out at the same edge. A write commits at the same edge.
  - Back-to-back strobes get one idle (ack low) cycle between acks.
  - data_out is 0 whenever ack_out is 0.
- Decode:
  - hit = addr_in[31:5] == BASE_ADDR[31:5]; register index = addr_in[4:2]; addr_in[1:0] ignored; full-word writes only.
  - Miss or unmapped index is still acked: reads return 0, writes are ignored.
- Register map (offset: name, access):
  - 0x00: CTRL, RW. bit0 EN, bit1 AUTORELOAD, bit2 IRQ_EN; other bits read 0.
  - 0x04: PRESCALE, RW, [PRESCALE_W-1:0]. One tick per PRESCALE+1 enabled clocks.
  - 0x08: COMPARE, RW, 32 bits.
  - 0x0C: COUNT, RW. A write loads the count and clears the prescaler counter.
  - 0x10: STATUS, bit0 MATCH. Reads the flag; writing 1 to bit0 clears it; writing 0 has no effect.
  - 0x14-0x1C: read 0, writes ignored.
- Counting:
  - EN=0: COUNT and prescaler counter hold; prescaler counter is cleared on the EN 1->0 edge.
  - EN=1: prescaler counter increments each clock. When it equals PRESCALE, it returns to 0 and a tick occurs that same edge.
  - On a tick with COUNT==COMPARE: MATCH<=1; COUNT <= AUTORELOAD ? 0 : COUNT+1.
  - On a tick otherwise: COUNT <= COUNT+1, wrapping 0xFFFF_FFFF -> 0 with no flag.
- irq = MATCH & IRQ_EN, registered; valid one cycle after either term changes.
- Simultaneous events:
  - Tick match and STATUS clear-write at the same edge: set wins, MATCH=1.
  - COUNT write and tick at the same edge: write wins; prescaler cleared; no match is evaluated that edge.
  - PRESCALE write while running: new value used immediately; prescaler counter cleared.
  - CTRL write that sets EN: counting starts with the next clock.
- Reset mid-transaction: ack_out is dropped immediately; the pending write is discarded; the master must retry.

Test Plan:
- Reset, then read 0x100..0x11C -> each acked one cycle after strobe, data 0; irq=0.
- Write COUNT=5, read COUNT -> 5. Write 0x120 (miss) = 0xDEAD -> acked, no register changes, read 0x120 -> 0.
- PRESCALE=3, COMPARE=2, CTRL=0x7 (EN, AUTORELOAD, IRQ_EN) -> tick every 4 clocks. COUNT sequence 0,1,2,0,1,2. MATCH sets on the tick at COUNT==2; irq rises one cycle later.
- AUTORELOAD=0, COUNT=0xFFFF_FFFE, COMPARE=0x10, PRESCALE=0, EN=1 -> COUNT goes FFFF_FFFF, 0, 1 with MATCH staying 0. Write STATUS=1 coincident with a match tick -> MATCH remains 1.
- Strobe held high for 6 cycles on a read -> ack pattern 1,0,1,0,1,0. Assert reset_n low during an acked write cycle -> ack_out 0 at once, target register 0.
- PRESCALE changed from 7 to 1 mid-count -> prescaler counter restarts at 0; next tick after 2 clocks.
